// File: rtl/e203_dtcm_icb2ram.sv
// ICB-to-SRAM bridge for the DTCM: one-cycle RAM read latency, response stage s1
// plus a single hold buffer so two responses can be outstanding without loss.
module e203_dtcm_icb2ram #(
    parameter int RAM_AW = 13,
    parameter int RAM_DW = 32,
    parameter int ICB_AW = 16,
    localparam int RAM_MW = RAM_DW / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic              icb_cmd_read,
    input  logic [ICB_AW-1:0] icb_cmd_addr,
    input  logic [RAM_DW-1:0] icb_cmd_wdata,
    input  logic [RAM_MW-1:0] icb_cmd_wmask,

    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [RAM_DW-1:0] icb_rsp_rdata,
    output logic              icb_rsp_err,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_MW-1:0] ram_wem,
    output logic [RAM_DW-1:0] ram_din,
    input  logic [RAM_DW-1:0] ram_dout,
    output logic              ram_sd,
    output logic              ram_ds,
    output logic              ram_ls
);

    logic              s1_vld_reg;
    logic              s1_read_reg;
    logic              s1_err_reg;
    logic              s1_fresh_reg;
    logic [RAM_DW-1:0] s1_rdata_reg;
    logic              hold_vld_reg;
    logic              hold_err_reg;
    logic [RAM_DW-1:0] hold_rdata_reg;

    logic              cmd_accept;
    logic              in_range;
    logic [RAM_DW-1:0] s1_rdata;
    logic              hold_load;
    logic              s1_keep;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^icb_cmd_addr[1:0];

    assign icb_cmd_ready = ~hold_vld_reg;
    assign cmd_accept    = icb_cmd_valid & icb_cmd_ready;
    assign in_range      = ~|icb_cmd_addr[ICB_AW-1:RAM_AW+2];

    assign ram_cs   = cmd_accept & in_range;
    assign ram_we   = ram_cs & ~icb_cmd_read;
    assign ram_addr = icb_cmd_addr[RAM_AW+1:2];
    assign ram_din  = icb_cmd_wdata;
    assign ram_sd   = 1'b0;
    assign ram_ds   = 1'b0;
    assign ram_ls   = 1'b0;

    generate
        for (genvar gi = 0; gi < RAM_MW; gi++) begin : g_wem
            assign ram_wem[gi] = ram_cs & icb_cmd_wmask[gi];
        end
    endgenerate

    // ram_dout is only trustworthy the cycle after the access, so a stalled s1
    // read keeps a private copy and uses it from the second cycle onward.
    assign s1_rdata = (s1_err_reg | ~s1_read_reg) ? '0 :
                      (s1_fresh_reg ? ram_dout : s1_rdata_reg);

    // s1 moves into hold when hold hands off (refill) or when s1 itself stalls
    // with hold empty; it only stays put when hold is stuck.
    assign hold_load = s1_vld_reg & (hold_vld_reg ? icb_rsp_ready : ~icb_rsp_ready);
    assign s1_keep   = s1_vld_reg & hold_vld_reg & ~icb_rsp_ready;

    assign icb_rsp_valid = hold_vld_reg | s1_vld_reg;
    assign icb_rsp_rdata = hold_vld_reg ? hold_rdata_reg : s1_rdata;
    assign icb_rsp_err   = hold_vld_reg ? hold_err_reg   : s1_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg   <= 1'b0;
            s1_fresh_reg <= 1'b0;
            hold_vld_reg <= 1'b0;
        end else begin
            s1_fresh_reg <= cmd_accept;
            if (cmd_accept) begin
                s1_vld_reg <= 1'b1;
            end else if (!s1_keep) begin
                s1_vld_reg <= 1'b0;
            end
            if (hold_load) begin
                hold_vld_reg <= 1'b1;
            end else if (hold_vld_reg && icb_rsp_ready) begin
                hold_vld_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_accept) begin
            s1_read_reg <= icb_cmd_read;
            s1_err_reg  <= ~in_range;
        end
        if (s1_fresh_reg) begin
            s1_rdata_reg <= ram_dout;
        end
        if (hold_load) begin
            hold_rdata_reg <= s1_rdata;
            hold_err_reg   <= s1_err_reg;
        end
    end

endmodule

// File: tb/tb_e203_dtcm_icb2ram.sv
// Directed and scoreboard-driven bench for e203_dtcm_icb2ram with a behavioural
// SRAM whose output is garbage except in the cycle after a read.
module tb_e203_dtcm_icb2ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic        icb_cmd_read;
    logic [15:0] icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        ram_cs;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        ram_sd;
    logic        ram_ds;
    logic        ram_ls;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:8191];
    logic [31:0] shadow [0:15];
    logic [31:0] exp_rdata_q[$];
    logic        exp_err_q[$];

    e203_dtcm_icb2ram dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs && !ram_we) begin
            ram_dout <= mem[ram_addr];
        end else begin
            ram_dout <= $urandom;
        end
        if (ram_cs && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated transaction with rsp_ready high: checks the RAM strobe in the
    // accept cycle and the response in the following cycle.
    task automatic single(input string tag, input logic rd, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wdata;
        icb_cmd_wmask = wmask;
        icb_rsp_ready = 1'b1;
        #1;
        chk({tag, "_cmd_ready"}, icb_cmd_ready, 1'b1);
        chk({tag, "_ram_cs"}, ram_cs, !exp_err);
        if (!exp_err) begin
            chk({tag, "_ram_we"}, ram_we, !rd);
            chk({tag, "_ram_addr"}, ram_addr, addr[14:2]);
        end
        chk({tag, "_rsp_early"}, icb_rsp_valid, 1'b0);
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        #1;
        chk({tag, "_rsp_valid"}, icb_rsp_valid, 1'b1);
        chk({tag, "_rsp_rdata"}, icb_rsp_rdata, exp_rdata);
        chk({tag, "_rsp_err"}, icb_rsp_err, exp_err);
        $display("txn %s rd=%0d addr=%h rdata=%h err=%0d", tag, rd, addr, icb_rsp_rdata, icb_rsp_err);
    endtask

    initial begin
        int accepted;
        int responded;
        int cyc;
        int word;
        logic oor;

        rst_n = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_read = 1'b0;
        icb_cmd_addr = '0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", icb_rsp_valid, 1'b0);
        chk("rst_cmd_ready", icb_cmd_ready, 1'b1);
        chk("rst_ram_cs", ram_cs, 1'b0);
        chk("rst_ram_pwr", {ram_sd, ram_ds, ram_ls}, 3'b000);
        rst_n = 1'b1;

        single("wr_full", 1'b0, 16'h0010, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        single("rd_full", 1'b1, 16'h0010, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        single("wr_part", 1'b0, 16'h0010, 32'hAABB_CCDD, 4'h2, 32'h0, 1'b0);
        single("rd_part", 1'b1, 16'h0010, 32'h0, 4'h0, 32'h1234_CC78, 1'b0);
        single("rd_unalg", 1'b1, 16'h0013, 32'h0, 4'h0, 32'h1234_CC78, 1'b0);
        single("rd_oor", 1'b1, 16'h8000, 32'h0, 4'h0, 32'h0, 1'b1);
        single("wr_oor", 1'b0, 16'h8004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);

        single("pre0", 1'b0, 16'h0000, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
        single("pre4", 1'b0, 16'h0004, 32'h2222_2222, 4'hF, 32'h0, 1'b0);
        single("pre8", 1'b0, 16'h0008, 32'h3333_3333, 4'hF, 32'h0, 1'b0);

        // Back-to-back reads with the response channel stalled.
        @(negedge clk);
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read = 1'b1;
        icb_cmd_addr = 16'h0000;
        #1;
        chk("b2b_a_ready", icb_cmd_ready, 1'b1);
        @(negedge clk);
        icb_cmd_addr = 16'h0004;
        #1;
        chk("b2b_b_ready", icb_cmd_ready, 1'b1);
        chk("b2b_b_rdata", icb_rsp_rdata, 32'h1111_1111);
        @(negedge clk);
        icb_cmd_addr = 16'h0008;
        #1;
        chk("b2b_ready_drop", icb_cmd_ready, 1'b0);
        chk("b2b_stall1_rdata", icb_rsp_rdata, 32'h1111_1111);
        @(negedge clk);
        #1;
        chk("b2b_stall2_ready", icb_cmd_ready, 1'b0);
        chk("b2b_stall2_rdata", icb_rsp_rdata, 32'h1111_1111);
        @(negedge clk);
        icb_rsp_ready = 1'b1;
        #1;
        chk("b2b_rsp0_valid", icb_rsp_valid, 1'b1);
        chk("b2b_rsp0_rdata", icb_rsp_rdata, 32'h1111_1111);
        @(negedge clk);
        #1;
        chk("b2b_rsp1_ready", icb_cmd_ready, 1'b0);
        chk("b2b_rsp1_rdata", icb_rsp_rdata, 32'h2222_2222);
        @(negedge clk);
        #1;
        chk("b2b_c_ready", icb_cmd_ready, 1'b1);
        chk("b2b_c_rsp_idle", icb_rsp_valid, 1'b0);
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        #1;
        chk("b2b_rsp2_valid", icb_rsp_valid, 1'b1);
        chk("b2b_rsp2_rdata", icb_rsp_rdata, 32'h3333_3333);
        @(negedge clk);
        #1;
        chk("b2b_drained", icb_rsp_valid, 1'b0);
        $display("txn b2b three stalled reads drained in order");

        // Random streaming against a shadow memory over words 0..15.
        for (int i = 0; i < 16; i++) begin
            shadow[i] = 32'h0101_0101 * i;
            single("init", 1'b0, 16'(i * 4), shadow[i], 4'hF, 32'h0, 1'b0);
        end
        accepted = 0;
        responded = 0;
        cyc = 0;
        while ((accepted < 100 || exp_rdata_q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            word = $urandom_range(0, 15);
            oor = ($urandom_range(0, 9) == 0);
            icb_cmd_valid = (accepted < 100) && ($urandom_range(0, 3) != 0);
            icb_cmd_read = $urandom_range(0, 1) == 1;
            icb_cmd_addr = {oor, 13'(word), 2'($urandom_range(0, 3))};
            icb_cmd_wdata = $urandom;
            icb_cmd_wmask = 4'($urandom_range(0, 15));
            icb_rsp_ready = (accepted >= 100) || ($urandom_range(0, 1) == 1);
            #1;
            if (icb_rsp_valid && icb_rsp_ready) begin
                if (exp_rdata_q.size() == 0) begin
                    chk("rnd_extra_rsp", 1'b1, 1'b0);
                end else begin
                    logic [31:0] er;
                    logic ee;
                    er = exp_rdata_q.pop_front();
                    ee = exp_err_q.pop_front();
                    chk("rnd_rdata", icb_rsp_rdata, er);
                    chk("rnd_err", icb_rsp_err, ee);
                    $display("txn rnd rsp %0d rdata=%h err=%0d", responded, icb_rsp_rdata, icb_rsp_err);
                end
                responded++;
            end
            if (icb_cmd_valid && icb_cmd_ready) begin
                if (oor) begin
                    exp_rdata_q.push_back(32'h0);
                    exp_err_q.push_back(1'b1);
                end else if (icb_cmd_read) begin
                    exp_rdata_q.push_back(shadow[word]);
                    exp_err_q.push_back(1'b0);
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (icb_cmd_wmask[b]) shadow[word][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                    end
                    exp_rdata_q.push_back(32'h0);
                    exp_err_q.push_back(1'b0);
                end
                accepted++;
            end
            cyc++;
        end
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        chk("rnd_accepted", accepted, 100);
        chk("rnd_responded", responded, 100);
        chk("rnd_queue_empty", exp_rdata_q.size(), 0);

        // Reset with both s1 and hold occupied.
        @(negedge clk);
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read = 1'b1;
        icb_cmd_addr = 16'h0000;
        @(negedge clk);
        icb_cmd_addr = 16'h0004;
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        #1;
        chk("rstmid_full_valid", icb_rsp_valid, 1'b1);
        chk("rstmid_full_ready", icb_cmd_ready, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rsp_valid", icb_rsp_valid, 1'b0);
        chk("rstmid_cmd_ready", icb_cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rstmid_no_spurious", icb_rsp_valid, 1'b0);
        end
        $display("txn reset mid-flight dropped outstanding responses");
        single("post_rst_rd", 1'b1, 16'h0000, 32'h0, 4'h0, shadow[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
